// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin arbiter that owns the select pair of a
// 4-to-1 mux. One requester holds the mux at a time; the select lines stay
// put while idle so the mux output never glitches between grants.
// Optional build macro: ARB_TIMEOUT_EN adds an 8-bit hold counter that
// forces a release after HOLD_MAX grant cycles and pulses timeout.
module mux4_rr_arbiter
`ifdef ARB_TIMEOUT_EN
#(
   parameter int unsigned HOLD_MAX = 16
)
`endif
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic [3:0] req,
   input  logic [3:0] done,
   output logic [3:0] grant,
   output logic [1:0] sel,
   output logic       busy,
   output logic       timeout
);

   localparam int unsigned N_REQ = 4;
   localparam int unsigned IDX_W = 2;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] idx_c;
   logic [IDX_W-1:0] cand_c;
   logic             found_c;
   logic             rel_c;

   // First requesting index at or above ptr, wrapping modulo 4.
   always_comb begin
      idx_c   = ptr;
      cand_c  = '0;
      found_c = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         cand_c = ptr + IDX_W'(k);
         if (!found_c && req[cand_c]) begin
            idx_c   = cand_c;
            found_c = 1'b1;
         end
      end
   end

   // Normal release: the holder signals done or withdraws its request.
   // sel always equals the holder index while in GRANT.
   always_comb begin
      rel_c = done[sel] | ~req[sel];
   end

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = 8;

   logic [CNT_W-1:0] hold_cnt;
   logic             to_c;

   // Forced release once the grant has lasted HOLD_MAX cycles.
   always_comb begin
      to_c = (hold_cnt == CNT_W'(HOLD_MAX - 1));
   end

   // Arbiter FSM with hold counter and timeout pulse.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         grant    <= '0;
         sel      <= '0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
         ptr      <= '0;
         hold_cnt <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (found_c) begin
                  grant    <= N_REQ'(1) << idx_c;
                  sel      <= idx_c;
                  busy     <= 1'b1;
                  hold_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (rel_c || to_c) begin
                  grant   <= '0;
                  busy    <= 1'b0;
                  ptr     <= sel + IDX_W'(1);
                  timeout <= ~rel_c;
                  state   <= IDLE;
               end else begin
                  hold_cnt <= hold_cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`else
   assign timeout = 1'b0;

   // Arbiter FSM; a grant lasts until done or request withdrawal.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         grant <= '0;
         sel   <= '0;
         busy  <= 1'b0;
         ptr   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found_c) begin
                  grant <= N_REQ'(1) << idx_c;
                  sel   <= idx_c;
                  busy  <= 1'b1;
                  state <= GRANT;
               end
            end
            GRANT: begin
               if (rel_c) begin
                  grant <= '0;
                  busy  <= 1'b0;
                  ptr   <= sel + IDX_W'(1);
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
`endif

endmodule
